// File: rtl/sw_debounce_latch.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce_latch
// Purpose  : 16-bit switch debouncer that hands debounced snapshots to a
//            serial LED shifter via a start/busy handshake, with a periodic
//            forced refresh so the display never holds stale data.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce_latch #(
   parameter int DIV_W     = 17,  // sample tick every 2^DIV_W clk cycles
   parameter int STABLE_N  = 4,   // consecutive differing samples to accept (2..7)
   parameter int REFRESH_W = 20   // forced refresh every 2^REFRESH_W clk cycles
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] sw_in,
   input  logic        busy,
   output logic [15:0] sw_db,
   output logic [15:0] p_data,
   output logic        start,
   output logic        pending
);

   // Request FSM encoding
   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_FIRE = 2'd1;
   localparam logic [1:0] C_WAIT = 2'd2;

   // Count value at which one more differing sample accepts the new level
   localparam logic [2:0] C_CNT_LAST = 3'(STABLE_N - 1);

   logic [15:0]          sync1_q;
   logic [15:0]          sync2_q;
   logic [DIV_W-1:0]     div_q,     div_d;
   logic [REFRESH_W-1:0] ref_q,     ref_d;
   logic [15:0][2:0]     cnt_q,     cnt_d;
   logic [15:0]          sw_db_q,   sw_db_d;
   logic [15:0]          p_data_q,  p_data_d;
   logic                 pending_q, pending_d;
   logic [1:0]           state_q,   state_d;

   logic                 tick;
   logic                 refresh;
   logic                 set_req;

   // Tick and refresh fire on the all-ones count, i.e. the cycle before wrap
   assign tick    = &div_q;
   assign refresh = &ref_q;
   assign start   = (state_q == C_FIRE);

   // Free-running prescaler and refresh counters
   always_comb begin
      div_d = div_q + DIV_W'(1);
      ref_d = ref_q + REFRESH_W'(1);
   end

   // Per-bit stability counting; only synchronizer outputs feed this logic
   always_comb begin
      cnt_d   = cnt_q;
      sw_db_d = sw_db_q;
      if (tick) begin
         for (int i = 0; i < 16; i++) begin
            if (sync2_q[i] != sw_db_q[i]) begin
               if (cnt_q[i] == C_CNT_LAST) begin
                  sw_db_d[i] = sync2_q[i];
                  cnt_d[i]   = 3'd0;
               end else begin
                  cnt_d[i]   = cnt_q[i] + 3'd1;
               end
            end else begin
               // A matching sample is a bounce: restart acceptance
               cnt_d[i] = 3'd0;
            end
         end
      end
   end

   // Pending request: a new set request wins over the clear from start
   always_comb begin
      set_req   = (sw_db_d != sw_db_q) || refresh;
      pending_d = set_req || (pending_q && !start);
   end

   // Frame request FSM; p_data snapshots sw_db only when a frame launches
   always_comb begin
      state_d  = state_q;
      p_data_d = p_data_q;
      case (state_q)
         C_IDLE: begin
            if (pending_q && !busy) begin
               state_d  = C_FIRE;
               p_data_d = sw_db_q;
            end
         end
         C_FIRE: begin
            state_d = C_WAIT;
         end
         C_WAIT: begin
            if (!busy) begin
               state_d = C_IDLE;
            end
         end
         default: begin
            state_d = C_IDLE;
         end
      endcase
   end

   // State registers; pending comes out of reset set so the display gets cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         div_q     <= '0;
         ref_q     <= '0;
         cnt_q     <= '0;
         sw_db_q   <= '0;
         p_data_q  <= '0;
         pending_q <= 1'b1;
         state_q   <= C_IDLE;
      end else begin
         sync1_q   <= sw_in;
         sync2_q   <= sync1_q;
         div_q     <= div_d;
         ref_q     <= ref_d;
         cnt_q     <= cnt_d;
         sw_db_q   <= sw_db_d;
         p_data_q  <= p_data_d;
         pending_q <= pending_d;
         state_q   <= state_d;
      end
   end

   assign sw_db   = sw_db_q;
   assign p_data  = p_data_q;
   assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce_latch
// Purpose  : Self-checking bench for sw_debounce_latch with a tick-sample
//            reference model and a five-cycle busy shifter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_debounce_latch;

   localparam int DIV_W     = 2;
   localparam int STABLE_N  = 3;
   localparam int REFRESH_W = 8;
   localparam int TICK_P    = 1 << DIV_W;
   localparam int REF_P     = 1 << REFRESH_W;

   logic        clk;
   logic        rst_n;
   logic [15:0] sw_in;
   logic        busy;
   logic [15:0] sw_db;
   logic [15:0] p_data;
   logic        start;
   logic        pending;

   int checks = 0;
   int errors = 0;

   // monitor results
   int          start_cnt   = 0;
   logic [15:0] last_pdata  = '0;
   logic [15:0] prev_pdata  = '0;
   logic        prev_rst    = 1'b0;

   // reference model state
   int          k = 0;
   logic [15:0] m_s1, m_s2, m_smp, m_tmp;
   logic [15:0] exp_db = '0;
   logic [15:0] tq[$];
   int          last_acc[16];
   int          m_n;
   logic        m_ok;

   // busy model
   int          bcnt = 0;

   sw_debounce_latch #(
      .DIV_W     (DIV_W),
      .STABLE_N  (STABLE_N),
      .REFRESH_W (REFRESH_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_in   (sw_in),
      .busy    (busy),
      .sw_db   (sw_db),
      .p_data  (p_data),
      .start   (start),
      .pending (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a bit flips once its last STABLE_N tick samples taken
   // since the previous acceptance all disagree with the debounced value.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            k = 0; m_s1 = '0; m_s2 = '0; exp_db = '0;
            tq.delete();
            for (int b = 0; b < 16; b++) last_acc[b] = -1;
         end else begin
            m_smp = m_s2; m_s2 = m_s1; m_s1 = sw_in;
            if ((k % TICK_P) == TICK_P - 1) begin
               tq.push_back(m_smp);
               m_n = tq.size() - 1;
               for (int b = 0; b < 16; b++) begin
                  if (m_n - last_acc[b] >= STABLE_N) begin
                     m_ok = 1'b1;
                     for (int j = m_n - STABLE_N + 1; j <= m_n; j++) begin
                        m_tmp = tq[j];
                        if (m_tmp[b] == exp_db[b]) m_ok = 1'b0;
                     end
                     if (m_ok) begin
                        exp_db[b]   = ~exp_db[b];
                        last_acc[b] = m_n;
                     end
                  end
               end
            end
            k++;
         end
      end
   end

   // Shifter model: busy for 5 cycles after each start
   initial begin
      busy = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (start === 1'b1) bcnt = 5;
         else if (bcnt > 0) bcnt--;
         busy = (bcnt > 0);
      end
   end

   // Continuous monitor: debounced value, start legality, p_data stability
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            checks++;
            if (sw_db !== exp_db) begin
               errors++;
               $display("FAIL sw_db_model t=%0t got %h want %h", $time, sw_db, exp_db);
            end
            if (start === 1'b1) begin
               start_cnt++;
               last_pdata = p_data;
               checks++;
               if (busy !== 1'b0) begin
                  errors++;
                  $display("FAIL start_while_busy t=%0t busy %b want 0", $time, busy);
               end
            end
            if (prev_rst === 1'b1) begin
               checks++;
               if (p_data !== prev_pdata && start !== 1'b1) begin
                  errors++;
                  $display("FAIL p_data_hold t=%0t got %h want %h", $time, p_data, prev_pdata);
               end
            end
         end
         prev_pdata = p_data;
         prev_rst   = rst_n;
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      while ((k % REF_P) != p && n < 600) begin
         step();
         n++;
      end
      checks++;
      if (n >= 600) begin
         errors++;
         $display("FAIL wait_phase got timeout want phase %0d", p);
      end
   endtask

   task automatic test_reset();
      int s0;
      sw_in = '0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      repeat (3) step();
      checks += 4;
      if (sw_db !== 16'h0)  begin errors++; $display("FAIL rst_sw_db got %h want 0000", sw_db); end
      if (p_data !== 16'h0) begin errors++; $display("FAIL rst_p_data got %h want 0000", p_data); end
      if (start !== 1'b0)   begin errors++; $display("FAIL rst_start got %b want 0", start); end
      if (pending !== 1'b1) begin errors++; $display("FAIL rst_pending got %b want 1", pending); end
      s0 = start_cnt;
      rst_n = 1'b1;
      repeat (2) step();
      checks += 3;
      if (start_cnt - s0 != 1) begin errors++; $display("FAIL post_rst_starts got %0d want 1", start_cnt - s0); end
      if (last_pdata !== 16'h0) begin errors++; $display("FAIL post_rst_pdata got %h want 0000", last_pdata); end
      if (pending !== 1'b0) begin errors++; $display("FAIL post_rst_pending got %b want 0", pending); end
   endtask

   task automatic test_bounce();
      int s0;
      wait_phase(20);
      s0 = start_cnt;
      for (int t = 0; t < 10; t++) begin
         sw_in[0] = ~sw_in[0];
         repeat (6) step();
      end
      sw_in = '0;
      repeat (20) step();
      checks += 2;
      if (sw_db[0] !== 1'b0) begin errors++; $display("FAIL bounce_bit0 got %b want 0", sw_db[0]); end
      if (start_cnt != s0) begin errors++; $display("FAIL bounce_starts got %0d want 0", start_cnt - s0); end
   endtask

   task automatic test_steady();
      int n = 0;
      int s0;
      sw_in = 16'hA5C3;
      step(); n = 1;
      while (sw_db !== 16'hA5C3 && n < 20) begin step(); n++; end
      checks++;
      if (n > 2 + STABLE_N * TICK_P) begin
         errors++;
         $display("FAIL steady_latency got %0d cycles want <= %0d", n, 2 + STABLE_N * TICK_P);
      end
      s0 = start_cnt;
      step();
      checks += 2;
      if (start_cnt != s0 + 1) begin errors++; $display("FAIL steady_start got %0d want 1", start_cnt - s0); end
      if (last_pdata !== 16'hA5C3) begin errors++; $display("FAIL steady_pdata got %h want a5c3", last_pdata); end
   endtask

   task automatic test_busy_change();
      int s0;
      int n = 0;
      s0 = start_cnt;
      sw_in = 16'h0001;
      while (start_cnt == s0 && n < 30) begin step(); n++; end
      checks++;
      if (start_cnt != s0 + 1 || last_pdata !== 16'h0001) begin
         errors++;
         $display("FAIL busy_first_frame got %0d/%h want 1/0001", start_cnt - s0, last_pdata);
      end
      sw_in = 16'h0002;
      s0 = start_cnt;
      n = 0;
      while (busy === 1'b1 && n < 10) begin
         checks++;
         if (p_data !== 16'h0001) begin errors++; $display("FAIL busy_hold got %h want 0001", p_data); end
         step(); n++;
      end
      repeat (40) step();
      checks += 2;
      if (start_cnt - s0 != 1) begin errors++; $display("FAIL busy_followup_starts got %0d want 1", start_cnt - s0); end
      if (last_pdata !== 16'h0002) begin errors++; $display("FAIL busy_followup_pdata got %h want 0002", last_pdata); end
   endtask

   task automatic test_refresh();
      int s0;
      wait_phase(20);
      s0 = start_cnt;
      repeat (REF_P) step();
      checks += 3;
      if (start_cnt - s0 != 1) begin errors++; $display("FAIL refresh_starts got %0d want 1", start_cnt - s0); end
      if (last_pdata !== exp_db) begin errors++; $display("FAIL refresh_pdata got %h want %h", last_pdata, exp_db); end
      if (pending !== 1'b0) begin errors++; $display("FAIL refresh_pending got %b want 0", pending); end
   endtask

   task automatic test_mid_reset();
      int s0;
      int n = 0;
      s0 = start_cnt;
      sw_in = 16'h1234;
      while (start_cnt == s0 && n < 30) begin step(); n++; end
      step();
      #1 rst_n = 1'b0;
      #1;
      checks += 4;
      if (sw_db !== 16'h0)  begin errors++; $display("FAIL abort_sw_db got %h want 0000", sw_db); end
      if (p_data !== 16'h0) begin errors++; $display("FAIL abort_p_data got %h want 0000", p_data); end
      if (start !== 1'b0)   begin errors++; $display("FAIL abort_start got %b want 0", start); end
      if (pending !== 1'b1) begin errors++; $display("FAIL abort_pending got %b want 1", pending); end
      repeat (2) step();
      rst_n = 1'b1;
      s0 = start_cnt;
      n = 0;
      while (start_cnt == s0 && n < 20) begin step(); n++; end
      checks++;
      if (start_cnt != s0 + 1 || last_pdata !== 16'h0) begin
         errors++;
         $display("FAIL abort_frame got %0d/%h want 1/0000", start_cnt - s0, last_pdata);
      end
      s0 = start_cnt;
      n = 0;
      while (start_cnt == s0 && n < 40) begin step(); n++; end
      checks++;
      if (start_cnt != s0 + 1 || last_pdata !== 16'h1234) begin
         errors++;
         $display("FAIL abort_next_frame got %0d/%h want 1/1234", start_cnt - s0, last_pdata);
      end
   endtask

   task automatic test_random();
      int cyc = 0;
      int hold;
      logic [15:0] mask;
      while (cyc < 1500) begin
         mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
         sw_in = sw_in ^ mask;
         hold = $urandom_range(1, 16);
         repeat (hold) step();
         cyc += hold;
      end
      repeat (40) step();
      wait_phase(100);
      checks += 2;
      if (last_pdata !== exp_db) begin errors++; $display("FAIL random_final_pdata got %h want %h", last_pdata, exp_db); end
      if (pending !== 1'b0) begin errors++; $display("FAIL random_final_pending got %b want 0", pending); end
   endtask

   initial begin
      sw_in = '0;
      rst_n = 1'b1;
      test_reset();
      test_bounce();
      test_steady();
      test_busy_change();
      test_refresh();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sw_debounce_latch.md
SW_DEBOUNCE_LATCH -- requirements
Module: sw_debounce_latch

Interface
REQ-001 Parameter DIV_W, default 17, sample tick period of 2^DIV_W clk cycles (1.31 ms at 100 MHz).
REQ-002 Parameter STABLE_N, default 4, range 2..7, consecutive differing samples needed to accept a new switch level.
REQ-003 Parameter REFRESH_W, default 20, forced refresh request every 2^REFRESH_W clk cycles.
REQ-004 clk  in  1  system clock; the block uses this single clock domain only.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 sw_in  in  16  raw asynchronous switch levels.
REQ-007 busy  in  1  downstream serial LED shifter is transferring a frame.
REQ-008 sw_db  out  16  debounced switch value.
REQ-009 p_data  out  16  frame data to the shifter, snapshot of sw_db.
REQ-010 start  out  1  one-cycle pulse that launches a shifter frame.
REQ-011 pending  out  1  a frame request is outstanding.

Function
REQ-012 Each sw_in bit shall pass through a 2-flop synchronizer; sw_db logic shall use only synchronizer outputs.
REQ-013 A free-running DIV_W-bit prescaler shall wrap to 0 and raise tick for one cycle when it equals all-ones.
REQ-014 Each bit shall have a 3-bit stability counter.
  - On tick, if the synchronized bit differs from its sw_db bit, the counter shall increment.
  - On tick, if the synchronized bit equals its sw_db bit, the counter shall clear to 0.
  - The counter shall not change between ticks.
REQ-015 When a counter is already STABLE_N-1 and a tick sees a difference, the sw_db bit shall take the synchronized value on that clock edge, and the counter shall clear.
REQ-016 A bounce shall restart acceptance: any tick where a bit matches sw_db clears that bit's count.
REQ-017 The REFRESH_W-bit refresh counter shall free-run and raise refresh for one cycle on wrap to 0.
REQ-018 The pending flag behaves as follows:
  - It shall be set on any cycle where at least one sw_db bit changes, or where refresh is high.
  - It shall clear on the cycle start is asserted.
  - If a set condition coincides with start, pending shall remain 1.
REQ-019 Request FSM, states IDLE, FIRE, WAIT:
  - IDLE -> FIRE when pending=1 and busy=0.
  - FIRE -> WAIT unconditionally.
  - WAIT -> IDLE when busy=0.
  - WAIT holds while busy=1.
REQ-020 start shall be 1 only in FIRE, exactly one cycle per frame, and never while busy was 1 in the preceding IDLE cycle.
REQ-021 On the IDLE->FIRE edge, p_data shall load sw_db, and p_data shall otherwise hold.
REQ-022 p_data shall be stable from FIRE through the end of WAIT, so sw_db changes during a transfer produce a following frame.
REQ-023 Worst-case switch-to-sw_db latency shall be 2 + STABLE_N*2^DIV_W cycles, and sw_db-change-to-start latency shall be 1 cycle when idle and busy=0.

Reset
REQ-024 While rst_n=0, the following shall hold regardless of clk:
  - Synchronizers, prescaler, stability counters, refresh counter, sw_db and p_data shall be 0.
  - start shall be 0.
  - The FSM shall be in IDLE.
REQ-025 pending shall reset to 1, so the first frame after reset clears the display.
REQ-026 Reset asserted mid-frame (FIRE or WAIT) shall abort to IDLE immediately, with no start pulse generated by the abort.

Verification (DIV_W=2, STABLE_N=3, REFRESH_W=8, busy model high 5 cycles after start)
REQ-027 Release rst_n with sw_in=0 -> one start pulse within 2 cycles, p_data=0x0000, and pending=0 afterwards.
REQ-028 sw_in=0xA5C3 held steady -> sw_db=0xA5C3 within 2+3*4 cycles, then start with p_data=0xA5C3.
REQ-029 Bit 0 toggling every 6 cycles (shorter than 3 ticks) -> sw_db bit 0 stays 0 and no start is caused by that bit.
REQ-030 sw_in changes from 0x0001 to 0x0002 while busy=1 -> p_data holds 0x0001 until busy falls, then exactly one further start with p_data=0x0002.
REQ-031 Idle 256 cycles with steady inputs -> exactly one refresh start, with p_data equal to the current sw_db.
REQ-032 rst_n pulsed low during WAIT -> outputs are 0 asynchronously and pending=1, then a normal frame follows release.
